// File: rtl/filter_stream_ctrl.sv
`timescale 1ns/1ps
// Stream controller for the 3x3 line-buffer filter: loads pixel rows into the filter,
// sweeps its cursor and emits filtered pixels. Define FILTER_CTRL_PERF_EN for stall_cnt.
module filter_stream_ctrl #(
    parameter int LINE_LEN    = 240,
    parameter int FRAME_LINES = 320,
    parameter int RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_eol,
    output logic        m_eof,
    output logic [15:0] f_d_in,
    output logic        f_wren,
    output logic [9:0]  f_cursor,
    input  logic [15:0] f_d_out,
    output logic        busy,
    output logic        frame_done
`ifdef FILTER_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, GAP, SWEEP, DONE} state_t;

    localparam logic [9:0] COL_LAST = 10'(LINE_LEN - 1);
    localparam logic [9:0] COL_END  = 10'(LINE_LEN);
    localparam logic [9:0] ROW_LAST = 10'(FRAME_LINES - 1);
    localparam int         WAIT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

    state_t            state;
    state_t            next_state;
    logic [9:0]        col;
    logic [9:0]        row;
    logic              gap_sweep;
    logic [WAIT_W-1:0] wait_cnt;

    logic s_accept;
    logic m_accept;
    logic border_col;
    logic sweep_end;

    assign s_ready    = (state == LOAD) && (col != COL_END);
    assign s_accept   = s_valid && s_ready;
    assign m_accept   = m_valid && m_ready;
    assign border_col = (col == 10'd0) || (col == COL_LAST);
    assign sweep_end  = (state == SWEEP) && m_accept && (col == COL_LAST);
    assign busy       = (state == LOAD) || (state == GAP) || (state == SWEEP);
    assign frame_done = (state == DONE);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (frame_start) next_state = LOAD;
            LOAD:    if (col == COL_END) next_state = GAP;
            GAP:     next_state = gap_sweep ? SWEEP : LOAD;
            SWEEP:   if (sweep_end) next_state = (row == ROW_LAST) ? DONE : GAP;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            gap_sweep <= 1'b0;
            wait_cnt  <= '0;
            f_d_in    <= '0;
            f_wren    <= 1'b0;
            f_cursor  <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_eol     <= 1'b0;
            m_eof     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    col       <= '0;
                    row       <= '0;
                    gap_sweep <= 1'b0;
                    f_wren    <= 1'b0;
                end
                LOAD: begin
                    // f_wren stays high across s_valid gaps so the filter sees
                    // one rising edge per row; the held word is simply rewritten.
                    if (s_accept) begin
                        f_d_in   <= s_data;
                        f_cursor <= col;
                        f_wren   <= 1'b1;
                        col      <= col + 10'd1;
                    end else if (col == COL_END) begin
                        f_wren    <= 1'b0;
                        col       <= '0;
                        gap_sweep <= (row >= 10'd2);
                    end
                end
                GAP: begin
                    if (!gap_sweep) begin
                        row <= row + 10'd1;
                    end
                    f_cursor <= '0;
                    wait_cnt <= '0;
                end
                SWEEP: begin
                    if (m_valid) begin
                        if (m_ready) begin
                            m_valid  <= 1'b0;
                            m_eol    <= 1'b0;
                            m_eof    <= 1'b0;
                            wait_cnt <= '0;
                            if (col == COL_LAST) begin
                                col       <= '0;
                                gap_sweep <= 1'b0;
                            end else begin
                                col      <= col + 10'd1;
                                f_cursor <= col + 10'd1;
                            end
                        end
                    end else if (border_col) begin
                        // Border columns have no full 3x3 window and output black.
                        m_data  <= '0;
                        m_valid <= 1'b1;
                        m_eol   <= (col == COL_LAST);
                        m_eof   <= (col == COL_LAST) && (row == ROW_LAST);
                    end else if (wait_cnt == WAIT_LAST) begin
                        m_data  <= f_d_out;
                        m_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DONE: begin
                    col <= '0;
                    row <= '0;
                end
                default: begin
                    col <= '0;
                    row <= '0;
                end
            endcase
        end
    end

`ifdef FILTER_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && frame_start) begin
            stall_cnt <= '0;
        end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filter_stream_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for filter_stream_ctrl with a behavioural 3x3 line-buffer filter
// (centre weight 4, four neighbours -1, per-channel saturation) attached.
module tb_filter_stream_ctrl;

    localparam int LL   = 8;
    localparam int FL   = 4;
    localparam int RL   = 2;
    localparam int NPIX = LL * FL;
    localparam int NOUT = (FL - 2) * LL;

    typedef struct {
        logic [15:0] d;
        logic        eol;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_eol;
    logic        m_eof;
    logic [15:0] f_d_in;
    logic        f_wren;
    logic [9:0]  f_cursor;
    logic [15:0] f_d_out;
    logic        busy;
    logic        frame_done;
`ifdef FILTER_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    exp_t        sb[$];
    logic [15:0] frame_px [NPIX];
    logic [15:0] out_log [NOUT];
    int          frame_out = 0;
    int          done_cnt = 0;
    int          wren_rises = 0;
    logic        wren_prev = 1'b0;
    int          last_cur = 0;
    int          ready_mode = 0;
    int          stall_left = 0;
    bit          stall_done = 1'b0;
    bit          abort = 1'b0;
    bit          hold_prev_valid = 1'b0;
    logic [15:0] prev_data = '0;
    logic [9:0]  prev_cur = '0;

    always #5 clk = ~clk;

    filter_stream_ctrl #(
        .LINE_LEN    (LL),
        .FRAME_LINES (FL),
        .RD_LAT      (RL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_eol       (m_eol),
        .m_eof       (m_eof),
        .f_d_in      (f_d_in),
        .f_wren      (f_wren),
        .f_cursor    (f_cursor),
        .f_d_out     (f_d_out),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef FILTER_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // 3x3 kernel with zero corners: 4*centre minus the four edge neighbours.
    function automatic logic [15:0] lap(input logic [15:0] c, input logic [15:0] n,
                                        input logic [15:0] s, input logic [15:0] w,
                                        input logic [15:0] e);
        int r;
        int g;
        int b;
        r = 4 * int'(c[15:11]) - int'(n[15:11]) - int'(s[15:11]) - int'(w[15:11]) - int'(e[15:11]);
        g = 4 * int'(c[10:5]) - int'(n[10:5]) - int'(s[10:5]) - int'(w[10:5]) - int'(e[10:5]);
        b = 4 * int'(c[4:0]) - int'(n[4:0]) - int'(s[4:0]) - int'(w[4:0]) - int'(e[4:0]);
        r = sat(r, 31);
        g = sat(g, 63);
        b = sat(b, 31);
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    // Behavioural filter: three row buffers, rotated on each f_wren rising edge,
    // d_out registered once so data is valid RD_LAT=2 clocks after a cursor change.
    logic [15:0] fbuf [3][LL];
    int          wp;
    logic        wren_q;

    function automatic logic [15:0] filt_at(input int c);
        int cl;
        int cr;
        int mid;
        int old;
        if (c >= LL) return 16'h0000;
        cl  = (c > 0) ? c - 1 : 0;
        cr  = (c < LL - 1) ? c + 1 : LL - 1;
        mid = (wp + 2) % 3;
        old = (wp + 1) % 3;
        return lap(fbuf[mid][c], fbuf[old][c], fbuf[wp][c], fbuf[mid][cl], fbuf[mid][cr]);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp      <= 2;
            wren_q  <= 1'b0;
            f_d_out <= '0;
        end else begin
            f_d_out <= filt_at(int'(f_cursor));
            if (f_wren && (int'(f_cursor) < LL)) begin
                fbuf[(!wren_q) ? (wp + 1) % 3 : wp][int'(f_cursor)] <= f_d_in;
                if (!wren_q) wp <= (wp + 1) % 3;
            end
            wren_q <= f_wren;
        end
    end

    // Reference: output row k is the kernel centred on input row k+1.
    function automatic logic [15:0] px(input int y, input int x);
        return frame_px[y * LL + x];
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < FL - 2; k++) begin
            for (int c = 0; c < LL; c++) begin
                if (c == 0 || c == LL - 1) e.d = 16'h0000;
                else e.d = lap(px(k + 1, c), px(k, c), px(k + 2, c), px(k + 1, c - 1), px(k + 1, c + 1));
                e.eol = (c == LL - 1);
                e.eof = (c == LL - 1) && (k == FL - 3);
                sb.push_back(e);
            end
        end
    endtask

    task automatic fill_frame(input int pmode);
        for (int i = 0; i < NPIX; i++) begin
            case (pmode)
                0:       frame_px[i] = 16'h0841;
                1:       frame_px[i] = (i == LL + 3) ? 16'h0841 : 16'h0000;
                default: frame_px[i] = 16'($urandom_range(0, 16'hFFFF));
            endcase
        end
    endtask

    // Monitor: handshakes, hold-during-stall, and the filter write stream.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                wren_prev       = 1'b0;
                hold_prev_valid = 1'b0;
            end else begin
                if (frame_done) done_cnt++;
                if (f_wren) begin
                    if (!wren_prev) begin
                        wren_rises++;
                        check("wr_first_cursor", 32'(f_cursor), 32'd0);
                    end else if (int'(f_cursor) != last_cur) begin
                        check("wr_cursor_step", 32'(f_cursor), 32'(last_cur + 1));
                    end
                    if (wren_rises >= 1 && wren_rises <= FL && int'(f_cursor) < LL)
                        check("wr_data", 32'(f_d_in), 32'(frame_px[(wren_rises - 1) * LL + int'(f_cursor)]));
                    last_cur = int'(f_cursor);
                end else if (wren_prev) begin
                    check("wr_last_cursor", 32'(last_cur), 32'(LL - 1));
                end
                wren_prev = f_wren;

                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none at %0t", m_data, $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("m_data", 32'(m_data), 32'(e.d));
                        check("m_eol", 32'(m_eol), 32'(e.eol));
                        check("m_eof", 32'(m_eof), 32'(e.eof));
                    end
                    if (frame_out < NOUT) out_log[frame_out] = m_data;
                    frame_out++;
                end

                if (m_valid && !m_ready) begin
                    if (hold_prev_valid) begin
                        check("hold_data", 32'(m_data), 32'(prev_data));
                        check("hold_cursor", 32'(f_cursor), 32'(prev_cur));
                    end
                    hold_prev_valid = 1'b1;
                    prev_data       = m_data;
                    prev_cur        = f_cursor;
                end else begin
                    hold_prev_valid = 1'b0;
                end
            end
        end
    end

    // Downstream ready: always, random, or one 5-cycle stall at the 4th beat.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else if (!stall_done && frame_out == 3 && m_valid) begin
                        m_ready    = 1'b0;
                        stall_left = 4;
                        stall_done = 1'b1;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic drive_rows(input int vmode, input bit start_busy);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < NPIX && cyc < 3000 && !abort) begin
            s_data = frame_px[idx];
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = ((cyc % 2) == 0);
                default: s_valid = ($urandom_range(0, 2) != 0);
            endcase
            frame_start = start_busy && (cyc == 20);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        s_valid     = 1'b0;
        frame_start = 1'b0;
        if (!abort) check("pixels_sent", 32'(idx), 32'(NPIX));
    endtask

    task automatic clear_frame_stats(input int rmode);
        frame_out  = 0;
        done_cnt   = 0;
        wren_rises = 0;
        ready_mode = rmode;
        stall_done = 1'b0;
        stall_left = 0;
    endtask

    task automatic run_frame(input int pmode, input int vmode, input int rmode,
                             input bit start_busy, input bit start_on_done);
        int n = 0;
        fill_frame(pmode);
        push_expected();
        clear_frame_stats(rmode);
        pulse_start();
        drive_rows(vmode, start_busy);
        while (!frame_done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 32'(frame_done), 32'd1);
        if (start_on_done) begin
            frame_start = 1'b1;
            @(posedge clk);
            #1;
            frame_start = 1'b0;
            check("done_width", 32'(frame_done), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("out_count", 32'(frame_out), 32'(NOUT));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("wren_rises", 32'(wren_rises), 32'(FL));
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        sb.delete();
    endtask

    task automatic reset_mid_sweep();
        fill_frame(2);
        push_expected();
        clear_frame_stats(0);
        abort = 1'b0;
        pulse_start();
        fork
            drive_rows(2, 1'b0);
            begin
                int n = 0;
                while (frame_out < 5 && n < 3000) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("sweep_reached", 32'(frame_out >= 5), 32'd1);
                abort   = 1'b1;
                reset_n = 1'b0;
                #1;
                check("rst_m_valid", 32'(m_valid), 32'd0);
                check("rst_f_wren", 32'(f_wren), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                sb.delete();
            end
        join
        @(negedge clk);
        check("rst_hold_m_valid", 32'(m_valid), 32'd0);
        check("rst_hold_s_ready", 32'(s_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        abort   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid0", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_eol", 32'(m_eol), 32'd0);
        check("rst_m_eof", 32'(m_eof), 32'd0);
        check("rst_f_wren0", 32'(f_wren), 32'd0);
        check("rst_f_cursor", 32'(f_cursor), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_s_ready", 32'(s_ready), 32'd0);

        // Flat frame: every output is black.
        run_frame(0, 0, 0, 1'b0, 1'b0);

        // Impulse at input row 1, col 3.
        run_frame(1, 0, 0, 1'b0, 1'b0);
        check("impulse_centre", 32'(out_log[3]), 32'h2104);
        check("impulse_left", 32'(out_log[2]), 32'h0000);
        check("impulse_right", 32'(out_log[4]), 32'h0000);

        // s_valid toggling during LOAD.
        run_frame(0, 1, 0, 1'b0, 1'b0);

        // Five-cycle m_ready stall mid-row.
        run_frame(2, 0, 2, 1'b0, 1'b0);

        // frame_start while busy, and frame_start coinciding with frame_done.
        run_frame(2, 2, 1, 1'b1, 1'b1);

        // Reset in the middle of a sweep, then a clean frame.
        reset_mid_sweep();
        run_frame(2, 0, 0, 1'b0, 1'b0);

        // Randomized frames with random valid/ready.
        for (int f = 0; f < 3; f++) run_frame(2, 2, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
